// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit with private HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO).
// Latency: mul/div results land in HI/LO after MUL_LAT/DIV_LAT busy cycles; MTHI/MTLO take one edge; rd_data is combinational.
// Backpressure: busy stalls the controller; start while busy is ignored. Divider compiled in only when MDU_DIV_EN is defined.
module mdu #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;

  // Down-counter reload values; both latencies must lie in 1..15.
  localparam logic [3:0] LP_MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] LP_DIV_CNT = 4'(DIV_LAT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;

  logic        w_is_mul_op;
  logic        w_is_div_op;
  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic [3:0]  w_lat;

  assign w_is_mul_op = (op == OP_MULT) | (op == OP_MULTU);

  // The low 64 bits of a product of sign-extended operands are the signed product.
  assign w_a_sx   = {{32{A[31]}}, A};
  assign w_b_sx   = {{32{B[31]}}, B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;

  assign w_is_div_op  = (op == OP_DIV) | (op == OP_DIVU);

  // Signed division is done on magnitudes, then signs are restored:
  // quotient negative when operand signs differ, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, negated back to itself, remainder 0.
  assign w_div_signed = (op == OP_DIV);
  assign w_a_neg      = w_div_signed & A[31];
  assign w_b_neg      = w_div_signed & B[31];
  assign w_a_mag      = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag      = w_b_neg ? (~B + 32'd1) : B;
  assign w_b_zero     = (B == 32'd0);
  // Keep the divider operand non-zero so its output is always defined.
  assign w_den        = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_den;
  assign w_r_mag      = w_a_mag % w_den;
  assign w_div_q      = w_b_zero ? 32'hFFFF_FFFF
                      : ((w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag);
  assign w_div_r      = w_b_zero ? A
                      : (w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag);
`else
  // Without the divider, DIV/DIVU are not recognised and behave as no-ops.
  assign w_is_div_op  = 1'b0;
`endif

  // Pick the full result to buffer and the busy length for the issued operation.
  always_comb begin
    w_res_hi = w_prod_u[63:32];
    w_res_lo = w_prod_u[31:0];
    w_lat    = w_is_div_op ? LP_DIV_CNT : LP_MUL_CNT;
    case (op)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        w_res_hi = w_div_r;
        w_res_lo = w_div_q;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM: accept in IDLE, count down in RUN, commit HI/LO on the last edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul_op | w_is_div_op) begin
              r_res_hi <= w_res_hi;
              r_res_lo <= w_res_lo;
              r_cnt    <= w_lat;
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
            end else if (op == OP_MTHI) begin
              r_hi <= A;
            end else if (op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          // Any start seen here is dropped; HI/LO keep pre-operation values until commit.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_res_hi;
            r_lo    <= r_res_lo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign hi_q    = r_hi;
  assign lo_q    = r_lo;
  // No bypass: a same-cycle MTHI/MTLO is not visible here until the next cycle.
  assign rd_data = (op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized + directed self-checking bench for mdu against an arithmetic reference model.
// Model tracks HI/LO and remaining busy cycles; results computed with 64-bit integer arithmetic.
// Expectations for DIV/DIVU follow the MDU_DIV_EN build setting.
module tb_mdu;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_res_hi = 32'd0;
  logic [31:0] m_res_lo = 32'd0;
  int          m_left = 0;

  mdu #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .rd_data(rd_data),
    .hi_q   (hi_q),
    .lo_q   (lo_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // {HI, LO} for a mul/div operation, straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (o)
      3'd0: r = 64'(sa * sb);
      3'd1: r = ua * ub;
      3'd2: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {32'(ua % ub), 32'(ua / ub)};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_md(input logic [2:0] o);
`ifdef MDU_DIV_EN
    return o <= 3'd3;
`else
    return o <= 3'd1;
`endif
  endfunction

  // Model behaviour at one rising edge, using the inputs presented before it.
  task automatic model_edge();
    if (m_left == 0) begin
      if (start && is_md(op)) begin
        {m_res_hi, m_res_lo} = ref_result(op, A, B);
        m_left = (op <= 3'd1) ? MUL_LAT : DIV_LAT;
      end else if (start && op == 3'd4) begin
        m_hi = A;
      end else if (start && op == 3'd5) begin
        m_lo = A;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("hi_q", hi_q, m_hi);
    chk("lo_q", lo_q, m_lo);
    chk("rd_data", rd_data, (op == 3'd6) ? m_hi : m_lo);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; op = 3'd7;
  endtask

  // Runs until busy drops (bounded) and returns the number of cycles busy was seen high,
  // including the cycle right after issue.
  task automatic wait_idle(output int n);
    int guard;
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) n++;
    end
    if (guard >= 40) chk("wait_idle_timeout", 32'(guard), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    int n;
    logic [31:0] old_hi, old_lo;

    // Reset state
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi_q, 32'd0);
    chk("rst_lo", lo_q, 32'd0);
    #9 reset_n = 1'b1;

    op = 3'd6; tick();
    chk("mfhi_after_reset", rd_data, 32'd0);
    op = 3'd7; tick();
    chk("mflo_after_reset", rd_data, 32'd0);

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_len", 32'(n), 32'(MUL_LAT));
    chk("mult_hi", hi_q, 32'hFFFF_FFFF);
    chk("mult_lo", lo_q, 32'hFFFF_FFFA);
    chk("mult_rd_lo", rd_data, 32'hFFFF_FFFA);

    // MULTU same operands
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("multu_hi", hi_q, 32'h0000_0002);
    chk("multu_lo", lo_q, 32'hFFFF_FFFA);

`ifdef MDU_DIV_EN
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_len", 32'(n), 32'(DIV_LAT));
    chk("div_lo", lo_q, 32'hFFFF_FFFD);
    chk("div_hi", hi_q, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    chk("divu0_lo", lo_q, 32'hFFFF_FFFF);
    chk("divu0_hi", hi_q, 32'd7);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", lo_q, 32'h8000_0000);
    chk("div_ovf_hi", hi_q, 32'd0);
`else
    old_hi = hi_q; old_lo = lo_q;
    issue(3'd2, 32'd8, 32'd2);
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("nodiv_hi", hi_q, old_hi);
    chk("nodiv_lo", lo_q, old_lo);
`endif

    // MTHI then MFHI next cycle
    issue(3'd4, 32'h1234_5678, 32'd0);
    op = 3'd6; #1;
    chk("mthi_mfhi", rd_data, 32'h1234_5678);
    tick();

    // MULT, MFLO during busy returns old LO, MTLO during busy is dropped
    issue(3'd5, 32'h0000_00AA, 32'd0);
    old_lo = lo_q;
    issue(3'd0, 32'd3, 32'd4);
    op = 3'd7; tick();
    chk("mflo_during_busy", rd_data, old_lo);
    start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF; tick();
    start = 1'b0; op = 3'd7;
    wait_idle(n);
    chk("mtlo_busy_dropped", lo_q, 32'd12);

    // Back-to-back: accepted in the first non-busy cycle
    issue(3'd1, 32'd5, 32'd6);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_len", 32'(n), 32'(MUL_LAT));
    chk("b2b_lo", lo_q, 32'd30);

    // Asynchronous reset mid-MULT
    issue(3'd0, 32'd7, 32'd9);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi_q, 32'd0);
    chk("arst_lo", lo_q, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    #2 reset_n = 1'b1;
    tick();

    // Randomized traffic, including starts while busy
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 40 && m_left > 0; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
